mac_seq_ctrl: RTL and testbench
===============================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the vector-memory address width; maximum vector length is 2**ADDR_W.
REQ-002 Parameter DRAIN_TO, default 8, SHALL set the drain timeout in cycles.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request a dot product; sampled only in IDLE.
REQ-006 len  in  ADDR_W+1  element count, 0..2**ADDR_W; captured on accepted start.
REQ-007 base_a, base_b  in  ADDR_W each  start addresses of vectors A and B; captured on accepted start.
REQ-008 rd_en  out  1  read strobe to both vector memories.
REQ-009 addr_a, addr_b  out  ADDR_W each  read addresses for vectors A and B.
REQ-010 rd_data_a, rd_data_b  in  8 each, signed  memory read data, valid exactly 1 cycle after rd_en.
REQ-011 mac_clr  out  1  accumulator clear to the MAC, wired to the MAC reset.
REQ-012 mac_valid, mac_a, mac_b  out  1/8/8  MAC operand strobe and signed operands.
REQ-013 mac_valid_out, mac_f  in  1/16 signed  MAC result strobe and accumulator value.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 result  out  16 signed  final dot product.
REQ-016 result_valid, result_ready  out/in  1/1  valid/ready handshake for result.
REQ-017 err  out  1  drain timeout flag; sticky until the next accepted start.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-019 IDLE: start=1 SHALL capture len, base_a and base_b, clear err, and go to CLEAR.
REQ-020 CLEAR: mac_clr=1 for exactly one cycle; next state STREAM, or DONE with result=0 if len=0.
REQ-021 STREAM: rd_en=1 for exactly len consecutive cycles, with addr_a=base_a+i and addr_b=base_b+i for i=0..len-1, wrapping mod 2**ADDR_W; then go to DRAIN.
REQ-022 mac_valid SHALL equal rd_en delayed by one register stage.
REQ-023 mac_a and mac_b SHALL pass rd_data_a and rd_data_b through combinationally, so that mac_valid=1 coincides with the returned data.
REQ-024 An output counter SHALL count mac_valid_out pulses from CLEAR onward; pulses in other states SHALL be ignored.
REQ-025 DRAIN: when the output count equals len, the FSM SHALL register mac_f (the value present with the len-th pulse) into result and go to DONE.
REQ-026 DRAIN timeout: if the count is not reached within DRAIN_TO cycles of entering DRAIN, the FSM SHALL set err=1, register result=mac_f, and go to DONE.
REQ-027 DONE: result_valid=1, with result held stable.
REQ-028 DONE exit: on the cycle result_valid=1 and result_ready=1, the FSM SHALL go to IDLE and result_valid SHALL drop next cycle.
REQ-029 result SHALL hold its value in IDLE until the next DONE.
REQ-030 start while busy=1 SHALL be ignored; there is no queueing.
REQ-031 The MAC is wrap-around 16-bit; the controller SHALL NOT saturate or modify mac_f.
REQ-032 Latency: for a MAC of 1-cycle capture plus 1-cycle accumulate, start to result_valid SHALL be len+5 cycles for len>=1.

Reset
REQ-033 On reset, the FSM SHALL go to IDLE from any state, including mid-STREAM or mid-DRAIN.
REQ-034 During reset, rd_en, mac_valid, busy, result_valid and err SHALL be 0.
REQ-035 During reset, result SHALL be 0 and all counters and captured addresses SHALL be 0.
REQ-036 During reset, mac_clr SHALL be 1, so the MAC accumulator is also cleared.
REQ-037 No output pulse from an aborted operation SHALL appear after reset deasserts.

Verification
REQ-038 len=4, A=[1,2,3,4], B=[5,6,7,8] at base 0 -> addr 0..3 in 4 consecutive cycles; result=70, result_valid at cycle 9 after start.
REQ-039 len=0 -> one mac_clr cycle, no rd_en, result=0, result_valid 2 cycles after start.
REQ-040 len=16, base_a=12 -> addr_a sequence 12..15,0..11 (wrap); result matches the golden sum mod 2**16.
REQ-041 result_ready held low 5 cycles in DONE -> result and result_valid held stable; start pulses in that window are ignored.
REQ-042 reset asserted on the 2nd STREAM cycle -> next cycle all outputs at reset values; a following len=2 op of (-3*4)+(127*-128) gives result=-16268.
REQ-043 MAC model drops one valid_out with len=3 -> err=1 and result_valid DRAIN_TO cycles after entering DRAIN; the next start clears err.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: streams len operand pairs to a MAC, collects len results, returns the sum.
// Latency len+5 cycles start->result_valid (2-stage MAC); result is held until result_ready.
module mac_seq_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int DRAIN_TO = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W:0]      len,
    input  logic [ADDR_W-1:0]    base_a,
    input  logic [ADDR_W-1:0]    base_b,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    addr_a,
    output logic [ADDR_W-1:0]    addr_b,
    input  logic signed [7:0]    rd_data_a,
    input  logic signed [7:0]    rd_data_b,
    output logic                 mac_clr,
    output logic                 mac_valid,
    output logic signed [7:0]    mac_a,
    output logic signed [7:0]    mac_b,
    input  logic                 mac_valid_out,
    input  logic signed [15:0]   mac_f,
    output logic                 busy,
    output logic signed [15:0]   result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 err
);
    localparam int TO_W = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t                state_q;
    logic [ADDR_W:0]       len_q;
    logic [ADDR_W-1:0]     base_a_q;
    logic [ADDR_W-1:0]     base_b_q;
    logic [ADDR_W-1:0]     addr_a_q;
    logic [ADDR_W-1:0]     addr_b_q;
    logic [ADDR_W:0]       idx_q;
    logic [ADDR_W:0]       out_cnt_q;
    logic [TO_W-1:0]       drain_q;
    logic                  rd_en_q;
    logic                  mac_valid_q;
    logic                  mac_clr_q;
    logic                  busy_q;
    logic signed [15:0]    result_q;
    logic                  result_valid_q;
    logic                  err_q;

    logic                  counting;
    logic [ADDR_W:0]       out_cnt_d;
    logic                  drain_hit;

    // out_cnt_d already includes this cycle's pulse, so the len-th result is taken the cycle it arrives.
    always_comb begin
        counting  = (state_q == CLEAR) || (state_q == STREAM) || (state_q == DRAIN);
        out_cnt_d = out_cnt_q;
        if (counting && mac_valid_out && (out_cnt_q != '1))
            out_cnt_d = out_cnt_q + (ADDR_W+1)'(1);
        drain_hit = (state_q == DRAIN) && (out_cnt_d == len_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            len_q          <= '0;
            base_a_q       <= '0;
            base_b_q       <= '0;
            addr_a_q       <= '0;
            addr_b_q       <= '0;
            idx_q          <= '0;
            out_cnt_q      <= '0;
            drain_q        <= '0;
            rd_en_q        <= 1'b0;
            mac_valid_q    <= 1'b0;
            mac_clr_q      <= 1'b1;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            mac_valid_q <= rd_en_q;
            mac_clr_q   <= 1'b0;
            out_cnt_q   <= out_cnt_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q     <= len;
                        base_a_q  <= base_a;
                        base_b_q  <= base_b;
                        err_q     <= 1'b0;
                        out_cnt_q <= '0;
                        mac_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (len_q == '0) begin
                        result_q       <= '0;
                        result_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        rd_en_q  <= 1'b1;
                        addr_a_q <= base_a_q;
                        addr_b_q <= base_b_q;
                        idx_q    <= (ADDR_W+1)'(1);
                        state_q  <= STREAM;
                    end
                end
                STREAM: begin
                    // idx_q counts reads already on the bus, including this cycle's.
                    if (idx_q == len_q) begin
                        rd_en_q <= 1'b0;
                        drain_q <= '0;
                        state_q <= DRAIN;
                    end else begin
                        addr_a_q <= addr_a_q + ADDR_W'(1);
                        addr_b_q <= addr_b_q + ADDR_W'(1);
                        idx_q    <= idx_q + (ADDR_W+1)'(1);
                    end
                end
                DRAIN: begin
                    if (drain_hit) begin
                        result_q       <= mac_f;
                        result_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end else if (drain_q == TO_W'(DRAIN_TO - 1)) begin
                        err_q          <= 1'b1;
                        result_q       <= mac_f;
                        result_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        drain_q <= drain_q + TO_W'(1);
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_en        = rd_en_q;
    assign addr_a       = addr_a_q;
    assign addr_b       = addr_b_q;
    assign mac_clr      = mac_clr_q;
    assign mac_valid    = mac_valid_q;
    assign mac_a        = rd_data_a;
    assign mac_b        = rd_data_b;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: behavioural memories and 2-stage MAC, dot-product golden model.
module tb_mac_seq_ctrl;
    localparam int ADDR_W   = 4;
    localparam int DRAIN_TO = 8;
    localparam int N        = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset, start, result_ready;
    logic [ADDR_W:0] len;
    logic [ADDR_W-1:0] base_a, base_b;
    logic rd_en, mac_clr, mac_valid, busy, result_valid, err;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic signed [7:0] rd_data_a = '0, rd_data_b = '0, mac_a, mac_b;
    logic mac_valid_out;
    logic signed [15:0] mac_f, result;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    mac_seq_ctrl #(.ADDR_W(ADDR_W), .DRAIN_TO(DRAIN_TO)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .base_a(base_a), .base_b(base_b), .rd_en(rd_en),
        .addr_a(addr_a), .addr_b(addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .mac_clr(mac_clr), .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
        .mac_valid_out(mac_valid_out), .mac_f(mac_f),
        .busy(busy), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .err(err)
    );

    // Vector memories: read data one cycle after rd_en.
    logic signed [7:0] mem_a [N];
    logic signed [7:0] mem_b [N];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[addr_a];
            rd_data_b <= mem_b[addr_b];
        end
    end

    // MAC: capture stage then accumulate stage; drop_idx suppresses that valid_out pulse (1-based).
    int drop_idx = 0;
    logic cap_v = 1'b0, vout = 1'b0;
    logic signed [7:0] cap_a = '0, cap_b = '0;
    logic signed [15:0] acc = '0;
    int vcount = 0;
    always @(posedge clk) begin
        if (mac_clr) begin
            cap_v <= 1'b0; acc <= '0; vout <= 1'b0; vcount <= 0;
        end else begin
            cap_v <= mac_valid; cap_a <= mac_a; cap_b <= mac_b;
            if (cap_v) begin
                acc    <= acc + cap_a * cap_b;
                vcount <= vcount + 1;
                vout   <= (vcount + 1 != drop_idx);
            end else begin
                vout <= 1'b0;
            end
        end
    end
    assign mac_valid_out = vout;
    assign mac_f         = acc;

    logic [ADDR_W-1:0] qa[$];
    logic [ADDR_W-1:0] qb[$];
    int clr_cycles = 0;
    int vout_cnt   = 0;
    always @(negedge clk) begin
        if (rd_en) begin qa.push_back(addr_a); qb.push_back(addr_b); end
        if (mac_clr && !reset) clr_cycles++;
        if (mac_valid_out) vout_cnt++;
    end

    function automatic logic signed [15:0] golden(input int l, input int ba, input int bb);
        int sum = 0;
        for (int i = 0; i < l; i++)
            sum += int'(mem_a[(ba + i) % N]) * int'(mem_b[(bb + i) % N]);
        return 16'(sum);
    endfunction

    function automatic bit addr_seq_ok(input int a0, input int l, input int ba, input int bb);
        if (qa.size() - a0 != l) return 1'b0;
        for (int i = 0; i < l; i++)
            if (int'(qa[a0 + i]) != (ba + i) % N || int'(qb[a0 + i]) != (bb + i) % N) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void fill_random();
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 8'($urandom);
            mem_b[i] = 8'($urandom);
        end
    endfunction

    // Issues one start; lat is the cycle (start cycle = 0) in which result_valid is first seen.
    task automatic do_op(input int l, input int ba, input int bb, output int lat, output int a0, output int nclr);
        @(negedge clk);
        a0 = qa.size(); nclr = clr_cycles;
        start = 1'b1; len = (ADDR_W+1)'(l); base_a = ADDR_W'(ba); base_b = ADDR_W'(bb);
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (!result_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({rd_en, mac_valid, busy, result_valid, err} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {rd_en, mac_valid, busy, result_valid, err});
        else pass_cnt++;
        chk_cnt++;
        if (result !== 16'sd0 || addr_a !== '0 || addr_b !== '0) $display("FAIL reset_data result=%0d addr_a=%0d addr_b=%0d want 0", result, addr_a, addr_b);
        else pass_cnt++;
        chk_cnt++;
        if (mac_clr !== 1'b1) $display("FAIL reset_mac_clr got %b want 1", mac_clr);
        else pass_cnt++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (mac_clr !== 1'b0 || busy !== 1'b0) $display("FAIL idle_after_reset mac_clr=%b busy=%b want 0 0", mac_clr, busy);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int lat, a0, nclr;
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 8'(i + 1);
            mem_b[i] = 8'(i + 5);
        end
        do_op(4, 0, 0, lat, a0, nclr);
        chk_cnt++;
        if (lat !== 9) $display("FAIL basic_latency got %0d want 9", lat); else pass_cnt++;
        chk_cnt++;
        if (result !== 16'sd70) $display("FAIL basic_result got %0d want 70", result); else pass_cnt++;
        chk_cnt++;
        if (!addr_seq_ok(a0, 4, 0, 0)) $display("FAIL basic_addr_seq got %0d reads want addr 0..3", qa.size() - a0); else pass_cnt++;
        chk_cnt++;
        if (clr_cycles - nclr !== 1) $display("FAIL basic_clr_cycles got %0d want 1", clr_cycles - nclr); else pass_cnt++;
        accept();
        chk_cnt++;
        if (result_valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_exit valid=%b busy=%b want 0 0", result_valid, busy); else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (result !== 16'sd70) $display("FAIL idle_hold_result got %0d want 70", result); else pass_cnt++;
    endtask

    task automatic test_len0();
        int lat, a0, nclr;
        do_op(0, 3, 5, lat, a0, nclr);
        chk_cnt++;
        if (lat !== 2) $display("FAIL len0_latency got %0d want 2", lat); else pass_cnt++;
        chk_cnt++;
        if (result !== 16'sd0) $display("FAIL len0_result got %0d want 0", result); else pass_cnt++;
        chk_cnt++;
        if (qa.size() != a0 || clr_cycles - nclr != 1)
            $display("FAIL len0_strobes reads=%0d clr=%0d want 0 1", qa.size() - a0, clr_cycles - nclr);
        else pass_cnt++;
        accept();
    endtask

    task automatic test_wrap();
        int lat, a0, nclr, bb;
        logic signed [15:0] exp;
        fill_random();
        bb = $urandom_range(0, N - 1);
        exp = golden(16, 12, bb);
        do_op(16, 12, bb, lat, a0, nclr);
        chk_cnt++;
        if (lat !== 21) $display("FAIL wrap_latency got %0d want 21", lat); else pass_cnt++;
        chk_cnt++;
        if (!addr_seq_ok(a0, 16, 12, bb)) $display("FAIL wrap_addr_seq first=%0d want 12 (base_b %0d)", qa[a0], bb); else pass_cnt++;
        chk_cnt++;
        if (result !== exp) $display("FAIL wrap_result got %0d want %0d", result, exp); else pass_cnt++;
        accept();
    endtask

    task automatic test_random();
        int lat, a0, nclr, l, ba, bb;
        logic signed [15:0] exp;
        for (int k = 0; k < 6; k++) begin
            fill_random();
            l  = $urandom_range(1, N);
            ba = $urandom_range(0, N - 1);
            bb = $urandom_range(0, N - 1);
            exp = golden(l, ba, bb);
            do_op(l, ba, bb, lat, a0, nclr);
            chk_cnt++;
            if (lat !== l + 5 || result !== exp || !addr_seq_ok(a0, l, ba, bb))
                $display("FAIL random_op%0d len=%0d lat=%0d want %0d result=%0d want %0d", k, l, lat, l + 5, result, exp);
            else pass_cnt++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept();
        end
    endtask

    task automatic test_hold_ready();
        int lat, a0, nclr;
        logic signed [15:0] exp;
        fill_random();
        exp = golden(3, 1, 2);
        do_op(3, 1, 2, lat, a0, nclr);
        for (int j = 0; j < 5; j++) begin
            chk_cnt++;
            if (result_valid !== 1'b1 || result !== exp || busy !== 1'b1)
                $display("FAIL hold_cycle%0d valid=%b result=%0d busy=%b want 1 %0d 1", j, result_valid, result, busy, exp);
            else pass_cnt++;
            start = (j % 2 == 0); len = 5'd7;
            @(negedge clk);
        end
        start = 1'b0;
        accept();
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0 || result !== exp) $display("FAIL hold_no_queue busy=%b result=%0d want 0 %0d", busy, result, exp); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat, a0, nclr, v0, r0;
        mem_a[0] = -8'sd3;  mem_a[1] = 8'sd127;
        mem_b[0] = 8'sd4;   mem_b[1] = -8'sd128;
        @(negedge clk);
        start = 1'b1; len = 5'd4; base_a = '0; base_b = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({rd_en, mac_valid, busy, result_valid, err} !== 5'b0 || mac_clr !== 1'b1 || result !== 16'sd0 || addr_a !== '0)
            $display("FAIL abort_reset flags=%b mac_clr=%b result=%0d addr_a=%0d want 00000 1 0 0",
                     {rd_en, mac_valid, busy, result_valid, err}, mac_clr, result, addr_a);
        else pass_cnt++;
        reset = 1'b0;
        v0 = vout_cnt; r0 = qa.size();
        repeat (10) @(negedge clk);
        chk_cnt++;
        if (vout_cnt != v0 || qa.size() != r0) $display("FAIL abort_leak vout=%0d reads=%0d want 0 0", vout_cnt - v0, qa.size() - r0); else pass_cnt++;
        do_op(2, 0, 0, lat, a0, nclr);
        chk_cnt++;
        if (result !== 16'(-16268) || lat !== 7) $display("FAIL post_abort_op result=%0d lat=%0d want -16268 7", result, lat); else pass_cnt++;
        accept();
    endtask

    task automatic test_timeout();
        int lat, a0, nclr, ba, bb;
        logic signed [15:0] exp;
        fill_random();
        ba = $urandom_range(0, N - 1);
        bb = $urandom_range(0, N - 1);
        exp = golden(3, ba, bb);
        drop_idx = 2;
        do_op(3, ba, bb, lat, a0, nclr);
        chk_cnt++;
        if (lat !== 3 + 2 + DRAIN_TO) $display("FAIL timeout_latency got %0d want %0d", lat, 3 + 2 + DRAIN_TO); else pass_cnt++;
        chk_cnt++;
        if (err !== 1'b1 || result !== exp) $display("FAIL timeout_err err=%b result=%0d want 1 %0d", err, result, exp); else pass_cnt++;
        accept();
        drop_idx = 0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else pass_cnt++;
        exp = golden(2, 0, 0);
        do_op(2, 0, 0, lat, a0, nclr);
        chk_cnt++;
        if (err !== 1'b0 || result !== exp || lat !== 7) $display("FAIL err_clear err=%b result=%0d lat=%0d want 0 %0d 7", err, result, lat, exp); else pass_cnt++;
        accept();
    endtask

    initial begin
        start = 1'b0; result_ready = 1'b0; len = '0; base_a = '0; base_b = '0;
        test_reset();
        test_basic();
        test_len0();
        test_wrap();
        test_random();
        test_hold_ready();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule
